// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_LW    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic       IORD_PC  = 1'b0;
    localparam logic       IORD_ALU = 1'b1;
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;
    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MDR  = 2'd1;
    localparam logic [1:0] M2R_PC   = 2'd2;
    localparam logic       A_PC     = 1'b0;
    localparam logic       A_REG    = 1'b1;
    localparam logic [1:0] B_REG    = 2'd0;
    localparam logic [1:0] B_FOUR   = 2'd1;
    localparam logic [1:0] B_SIMM   = 2'd2;
    localparam logic [1:0] B_ZIMM   = 2'd3;
    localparam logic [1:0] PC_ALU   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;
    localparam logic [1:0] PC_REG   = 2'd3;

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: picks alu_ctrl from the current state and instruction
// fields, and flags whether the R-type funct is one the datapath supports.
module mc_alu_dec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_ok
);

    always_comb begin
        funct_ok = 1'b1;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (state)
            S_EXEC_R: begin
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                case (opcode)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_BRANCH: alu_ctrl = ALU_SUB;
            default:  alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style controller: state register plus combinational decode
// of datapath enables and mux selects from state and instruction fields.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal
);

    state_t state_q;
    state_t state_d;
    logic   funct_ok;

    mc_alu_dec u_alu_dec (
        .state    (state_q),
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (alu_ctrl),
        .funct_ok (funct_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = S_FETCH;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = IORD_PC;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = A_PC;
        alu_src_b  = B_REG;
        pc_src     = PC_ALU;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = B_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = B_SIMM;
                if (opcode == OP_RTYPE)                       state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEM_ADDR;
                else if (is_imm_alu(opcode))                  state_d = S_EXEC_I;
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
                else if (opcode == OP_J || opcode == OP_JAL)  state_d = S_JUMP;
                else                                          illegal = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = A_REG;
                alu_src_b = B_REG;
                illegal   = ~funct_ok;
                state_d   = funct_ok ? S_WB_R : S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = A_REG;
                alu_src_b = (opcode == OP_ANDI || opcode == OP_ORI) ? B_ZIMM : B_SIMM;
                state_d   = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_src_a = A_REG;
                alu_src_b = B_SIMM;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord    = IORD_ALU;
                mem_rd  = 1'b1;
                state_d = mem_ready ? S_WB_LW : S_MEM_RD;
            end
            S_MEM_WR: begin
                iord    = IORD_ALU;
                mem_wr  = 1'b1;
                state_d = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = DST_RD;
            end
            S_WB_I: reg_we = 1'b1;
            S_WB_LW: begin
                reg_we     = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            S_BRANCH: begin
                alu_src_a = A_REG;
                alu_src_b = B_REG;
                pc_src    = PC_BR;
                pc_we     = (opcode == OP_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pc_src = PC_JMP;
                pc_we  = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_we     = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = M2R_PC;
                end
            end
            S_JR: begin
                pc_src = PC_REG;
                pc_we  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset is asynchronous, so enables must drop in the same cycle it rises.
        if (rst) begin
            mem_rd  = 1'b0;
            mem_wr  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: each instruction is expanded into its phase
// sequence and every cycle's outputs are compared against the expected set.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_rd, mem_wr, iord, ir_we, pc_we, reg_we;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a, illegal;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_src(pc_src), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic mrd, mwr, iord, irwe, pcwe, regwe;
        logic [1:0] rdst, m2r;
        logic asa;
        logic [1:0] asb;
        logic [2:0] alu;
        logic [1:0] psrc;
        logic ill;
    } obs_t;

    int  plan[$];
    bit  rdy_q[$];
    bit  rand_rdy = 0;
    int  ncyc, n_regwe, n_mem_iord, n_collide;

    function automatic bit is_imm(input logic [5:0] op);
        return op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010;
    endfunction

    function automatic bit funct_valid(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Phase sequence an instruction walks through (state codes as numbered externally).
    function automatic void build_plan(input logic [5:0] op, input logic [5:0] fn);
        plan.delete();
        plan.push_back(0);
        plan.push_back(1);
        if (op == 6'b000000) begin
            if (fn == 6'b001000) plan.push_back(12);
            else begin
                plan.push_back(2);
                if (funct_valid(fn)) plan.push_back(7);
            end
        end else if (op == 6'b100011) begin
            plan.push_back(4); plan.push_back(5); plan.push_back(9);
        end else if (op == 6'b101011) begin
            plan.push_back(4); plan.push_back(6);
        end else if (is_imm(op)) begin
            plan.push_back(3); plan.push_back(8);
        end else if (op == 6'b000100 || op == 6'b000101) plan.push_back(10);
        else if (op == 6'b000010 || op == 6'b000011) plan.push_back(11);
    endfunction

    function automatic bit decode_ok(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || is_imm(op) ||
               op == 6'b000100 || op == 6'b000101 || op == 6'b000010 || op == 6'b000011;
    endfunction

    function automatic void model(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                  input bit z, input bit rdy, output obs_t e, output obs_t c);
        e = '0;
        c = '0;
        c.st = '1; c.mrd = 1; c.mwr = 1; c.irwe = 1; c.pcwe = 1; c.regwe = 1; c.ill = 1;
        e.st = 4'(ph);
        case (ph)
            0: begin
                e.mrd = 1; e.irwe = rdy; e.pcwe = rdy; e.asb = 2'd1; e.alu = 3'b010;
                c.iord = 1; c.asa = 1; c.asb = '1; c.alu = '1; c.psrc = '1;
            end
            1: begin
                e.asb = 2'd2; e.alu = 3'b010; e.ill = !decode_ok(op);
                c.asa = 1; c.asb = '1; c.alu = '1;
            end
            2: begin
                e.asa = 1; e.asb = 2'd0; e.ill = !funct_valid(fn); e.alu = funct_alu(fn);
                c.asa = 1; c.asb = '1;
                if (funct_valid(fn)) c.alu = '1;
            end
            3: begin
                e.asb = (op == 6'b001100 || op == 6'b001101) ? 2'd3 : 2'd2;
                e.alu = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 :
                        (op == 6'b001010) ? 3'b111 : 3'b010;
                c.asb = '1; c.alu = '1;
            end
            4: begin
                e.asa = 1; e.asb = 2'd2; e.alu = 3'b010;
                c.asa = 1; c.asb = '1; c.alu = '1;
            end
            5: begin e.iord = 1; e.mrd = 1; c.iord = 1; end
            6: begin e.iord = 1; e.mwr = 1; c.iord = 1; end
            7: begin e.regwe = 1; e.rdst = 2'd1; e.m2r = 2'd0; c.rdst = '1; c.m2r = '1; end
            8: begin e.regwe = 1; e.rdst = 2'd0; e.m2r = 2'd0; c.rdst = '1; c.m2r = '1; end
            9: begin e.regwe = 1; e.rdst = 2'd0; e.m2r = 2'd1; c.rdst = '1; c.m2r = '1; end
            10: begin
                e.alu = 3'b110; e.asa = 1; e.asb = 2'd0; e.psrc = 2'd1;
                e.pcwe = (op == 6'b000100) ? z : !z;
                c.alu = '1; c.asa = 1; c.asb = '1; c.psrc = '1;
            end
            11: begin
                e.psrc = 2'd2; e.pcwe = 1; c.psrc = '1;
                if (op == 6'b000011) begin
                    e.regwe = 1; e.rdst = 2'd2; e.m2r = 2'd2; c.rdst = '1; c.m2r = '1;
                end
            end
            12: begin e.psrc = 2'd3; e.pcwe = 1; c.psrc = '1; end
            default: ;
        endcase
    endfunction

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input bit z);
        int   idx = 0;
        int   ph;
        bit   rdy;
        obs_t o, e, c;
        build_plan(op, fn);
        ncyc = 0; n_regwe = 0; n_mem_iord = 0; n_collide = 0;
        while (idx < plan.size()) begin
            @(negedge clk);
            if (idx == 0 && ncyc == 0) begin
                opcode = op; funct = fn; zero = z;
            end
            if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
            else if (rand_rdy)    rdy = ($urandom_range(0, 9) > 2);
            else                  rdy = 1'b1;
            mem_ready = rdy;
            #1;
            ph = plan[idx];
            model(ph, op, fn, z, rdy, e, c);
            o = {state, mem_rd, mem_wr, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal};
            total++;
            if ((o & c) !== (e & c)) begin
                bad++;
                $display("FAIL %s cyc=%0d phase=%0d got=%h want=%h care=%h",
                         name, ncyc, ph, o, e, c);
            end
            ncyc++;
            if (reg_we) n_regwe++;
            if (mem_rd && iord) n_mem_iord++;
            if (mem_rd && mem_wr) n_collide++;
            if (!(ph == 0 || ph == 5 || ph == 6) || rdy) idx++;
            if (ncyc > 60) begin
                bad++;
                $display("FAIL %s_timeout got=%0d cycles want<=60", name, ncyc);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++;
        if ({mem_rd, mem_wr, ir_we, pc_we, reg_we, illegal} !== 6'b0) begin
            bad++; $display("FAIL reset_enables got=%b want=000000",
                            {mem_rd, mem_wr, ir_we, pc_we, reg_we, illegal});
        end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; #1;
        total++;
        if (state !== 4'd0 || mem_rd !== 1'b1) begin
            bad++; $display("FAIL reset_release got state=%0d mem_rd=%b want 0/1", state, mem_rd);
        end
    endtask

    task automatic test_add();
        run_instr("add", 6'b000000, 6'b100000, 1'b0);
        total++;
        if (ncyc !== 4 || n_regwe !== 1) begin
            bad++; $display("FAIL add_latency got cyc=%0d regwe=%0d want 4/1", ncyc, n_regwe);
        end
        run_instr("sub", 6'b000000, 6'b100010, 1'b1);
        run_instr("slti", 6'b001010, 6'b000000, 1'b0);
        run_instr("ori", 6'b001101, 6'b111111, 1'b0);
        run_instr("sw", 6'b101011, 6'b000000, 1'b0);
        total++;
        if (ncyc !== 4) begin bad++; $display("FAIL sw_latency got=%0d want=4", ncyc); end
        run_instr("jr", 6'b000000, 6'b001000, 1'b0);
        total++;
        if (ncyc !== 3) begin bad++; $display("FAIL jr_latency got=%0d want=3", ncyc); end
    endtask

    task automatic test_lw_stall();
        rdy_q = '{1, 1, 1, 0, 0, 0, 1, 1};
        run_instr("lw_stall", 6'b100011, 6'b000000, 1'b0);
        total++;
        if (ncyc !== 8) begin bad++; $display("FAIL lw_total got=%0d want=8", ncyc); end
        total++;
        if (n_mem_iord !== 4) begin bad++; $display("FAIL lw_mrd_hold got=%0d want=4", n_mem_iord); end
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1);
        run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0);
        run_instr("bne_z1", 6'b000101, 6'b000000, 1'b1);
        run_instr("bne_z0", 6'b000101, 6'b000000, 1'b0);
        total++;
        if (ncyc !== 3) begin bad++; $display("FAIL bne_latency got=%0d want=3", ncyc); end
    endtask

    task automatic test_jump_illegal();
        run_instr("jal", 6'b000011, 6'b000000, 1'b0);
        total++;
        if (ncyc !== 3 || n_regwe !== 1) begin
            bad++; $display("FAIL jal_shape got cyc=%0d regwe=%0d want 3/1", ncyc, n_regwe);
        end
        run_instr("j", 6'b000010, 6'b000000, 1'b0);
        run_instr("bad_op", 6'b111111, 6'b000000, 1'b0);
        total++;
        if (ncyc !== 2 || n_regwe !== 0) begin
            bad++; $display("FAIL illegal_op got cyc=%0d regwe=%0d want 2/0", ncyc, n_regwe);
        end
        run_instr("bad_funct", 6'b000000, 6'b000111, 1'b0);
        run_instr("after_illegal", 6'b001100, 6'b000000, 1'b0);
    endtask

    task automatic test_reset_mid_memwr();
        opcode = 6'b101011; funct = 6'b000000; zero = 1'b0;
        repeat (3) begin
            @(negedge clk); mem_ready = 1'b1;
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        total++;
        if (state !== 4'd6 || mem_wr !== 1'b1) begin
            bad++; $display("FAIL memwr_reach got state=%0d mem_wr=%b want 6/1", state, mem_wr);
        end
        #1 rst = 1'b1; #1;
        total++;
        if (state !== 4'd0 || mem_wr !== 1'b0 || mem_rd !== 1'b0) begin
            bad++; $display("FAIL memwr_abort got state=%0d wr=%b rd=%b want 0/0/0",
                            state, mem_wr, mem_rd);
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        total++;
        if (state !== 4'd0 || mem_rd !== 1'b1 || reg_we !== 1'b0) begin
            bad++; $display("FAIL memwr_release got state=%0d rd=%b we=%b want 0/1/0",
                            state, mem_rd, reg_we);
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [5:0] ops[13] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b001000,
                                6'b001100, 6'b001101, 6'b001010, 6'b000100, 6'b000101,
                                6'b000010, 6'b000011, 6'b000000};
        logic [5:0] fns[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b001000, 6'b000000};
        logic [5:0] op, fn;
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr("random", op, fn, 1'($urandom));
            total++;
            if (n_regwe > 1 || n_collide != 0) begin
                bad++; $display("FAIL random_invariant got regwe=%0d collide=%0d want <=1/0",
                                n_regwe, n_collide);
            end
        end
        rand_rdy = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_jump_illegal();
        test_reset_mid_memwr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 opcode  in  6  instruction bits [31:26] from instruction register.
REQ-005 funct  in  6  instruction bits [5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes current access this cycle.
REQ-008 mem_rd, mem_wr  out  1 each  memory read / write request.
REQ-009 iord  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-010 ir_we, pc_we  out  1 each  instruction register / PC write enable.
REQ-011 reg_we  out  1  register-file write enable, drives its L_S input.
REQ-012 reg_dst  out  2  write address: 0=rt, 1=rd, 2=r31.
REQ-013 mem_to_reg  out  2  write data: 0=ALU result register, 1=MDR, 2=PC.
REQ-014 alu_src_a  out  1; alu_src_b  out  2  A: 0=PC, 1=rdata_A; B: 0=rdata_B, 1=4, 2=sign-ext imm, 3=zero-ext imm.
REQ-015 alu_ctrl  out  3; pc_src  out  2  ALU op (000 and, 001 or, 010 add, 110 sub, 111 slt); PC source: 0=ALU, 1=branch target, 2=jump target, 3=rdata_A.
REQ-016 state  out  4  current state (debug); illegal  out  1  one-cycle pulse on unsupported opcode/funct.

Function
REQ-017 States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_LW 9, BRANCH 10, JUMP 11, JR 12; 13-15 SHALL return to FETCH.
REQ-018 Outputs SHALL be combinational from state plus opcode/funct/zero/mem_ready; unlisted enables 0.
REQ-019 FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=add, pc_src=0; ir_we=pc_we=1 only when mem_ready=1; stay until mem_ready, then DECODE.
REQ-020 DECODE: ALU computes branch target (A=PC, B=sign-ext imm shifted, add); next: R-type(000000) -> EXEC_R, or JR if funct=001000; lw/sw(100011/101011) -> MEM_ADDR; addi/andi/ori/slti(001000/001100/001101/001010) -> EXEC_I; beq/bne(000100/000101) -> BRANCH; j/jal(000010/000011) -> JUMP; other -> FETCH with illegal=1.
REQ-021 EXEC_R: A=rdata_A, B=rdata_B, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); unknown funct -> illegal=1, FETCH, no write; else -> WB_R.
REQ-022 EXEC_I: B=2 for addi/slti, 3 for andi/ori; alu_ctrl add/slt/and/or; -> WB_I.
REQ-023 WB_R: reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH. WB_I: reg_we=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-024 MEM_ADDR: A=rdata_A, B=2, add; -> MEM_RD (lw) or MEM_WR (sw).
REQ-025 MEM_RD/MEM_WR: iord=1, mem_rd/mem_wr=1 held until mem_ready; then WB_LW (lw) or FETCH (sw).
REQ-026 WB_LW: reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-027 BRANCH: alu_ctrl=sub, A=rdata_A, B=0, pc_src=1; pc_we=zero (beq) or ~zero (bne) -> FETCH.
REQ-028 JUMP: pc_src=2, pc_we=1; jal additionally reg_we=1, reg_dst=2, mem_to_reg=2 -> FETCH. JR: pc_src=3, pc_we=1 -> FETCH.
REQ-029 Latency with mem_ready tied 1: R/I-type 4, lw 5, sw 4, beq/bne/j/jal/jr 3 cycles.
REQ-030 Controller SHALL assert reg_we for destination 0 unchanged; suppression belongs to the register file.
REQ-031 mem_rd and mem_wr SHALL never be high together; reg_we SHALL be high in at most one cycle per instruction.

Reset
REQ-032 rst high: state=FETCH asynchronously; all enables (mem_rd, mem_wr, ir_we, pc_we, reg_we) and illegal forced 0 while rst high.
REQ-033 rst mid-instruction SHALL abandon it with no further write; first cycle after release is FETCH.

Structure
REQ-034 Package mc_pkg SHALL hold state encodings, opcode/funct constants, alu_ctrl codes and mux-select codes.
REQ-035 Sub-module mc_alu_dec SHALL map state/opcode/funct to alu_ctrl and funct validity.

Verification
REQ-036 add $3,$1,$2 (op 0, funct 100000), mem_ready=1 -> states 0,1,2,7; reg_we=1 with reg_dst=1 in cycle 4 only.
REQ-037 lw with mem_ready low 3 cycles in MEM_RD -> mem_rd, iord held 4 cycles, then WB_LW with mem_to_reg=1; total 8 cycles.
REQ-038 beq zero=1 -> pc_we=1, pc_src=1 in cycle 3; bne zero=1 -> pc_we=0.
REQ-039 jal -> cycle 3 pc_we=1, reg_we=1, reg_dst=2, mem_to_reg=2; opcode 111111 -> illegal pulse in DECODE, next FETCH, no writes.
REQ-040 rst asserted during MEM_WR with mem_ready=0 -> mem_wr drops same cycle, state=0; after release FETCH with mem_rd=1.
